// File: rtl/reset_sequencer.sv
// Reset release sequencer: waits for a filtered PLL lock, then releases
// core, display and scan-driver resets in order, STAGE_DLY cycles apart.
// Ports: clk, asyncrst_n (async active-low), pll_locked (async),
//   sw_rst_req (re-sequence), rst_core_n/rst_disp_n/rst_scan_n,
//   seq_done, seq_state[2:0]; with RSTSEQ_WDT_EN also wdt_kick, wdt_fired.
// Optional watchdog in DONE is enabled by defining RSTSEQ_WDT_EN.
module reset_sequencer #(
  parameter int LOCK_FILTER = 8,
  parameter int STAGE_DLY   = 16,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       asyncrst_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
`ifdef RSTSEQ_WDT_EN
  input  logic       wdt_kick,
  output logic       wdt_fired,
`endif
  output logic       rst_core_n,
  output logic       rst_disp_n,
  output logic       rst_scan_n,
  output logic       seq_done,
  output logic [2:0] seq_state
);

  localparam int CMAX =
    (LOCK_FILTER > STAGE_DLY) ? LOCK_FILTER : STAGE_DLY;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    LOCK_WAIT = 3'd1,
    REL_CORE  = 3'd2,
    REL_DISP  = 3'd3,
    REL_SCAN  = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic            sync_q, locked_s;
  logic            abort;
  logic            wdt_exp;

  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

`ifdef RSTSEQ_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wcnt;

  assign wdt_exp = (state == DONE) && !wdt_kick &&
                   (wcnt == WW'(WDT_CYCLES - 1));

  // Counts only while staying in DONE, so entry clears it.
  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      wcnt      <= '0;
      wdt_fired <= 1'b0;
    end else begin
      if (state == DONE && state_nxt == DONE && !wdt_kick)
        wcnt <= wcnt + WW'(1);
      else
        wcnt <= '0;
      if (wdt_exp)
        wdt_fired <= 1'b1;
    end
  end
`else
  assign wdt_exp = 1'b0;
`endif

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  assign abort = (state != HOLD) &&
                 (sw_rst_req ||
                  (!locked_s && state >= REL_CORE));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      HOLD: begin
        if (!sw_rst_req) state_nxt = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        // Count holds the number of earlier high cycles in this run.
        if (locked_s) begin
          if (cnt == CW'(LOCK_FILTER - 1))
            state_nxt = REL_CORE;
          else
            cnt_nxt = cnt_inc;
        end
      end
      REL_CORE, REL_DISP, REL_SCAN: begin
        if (cnt == CW'(STAGE_DLY - 1))
          state_nxt = state_t'(state + 3'd1);
        else
          cnt_nxt = cnt_inc;
      end
      DONE: begin
        if (wdt_exp) state_nxt = HOLD;
      end
      default: state_nxt = HOLD;
    endcase
    if (abort) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
    end
  end

  // Outputs decode the next state so they flip with the state flop.
  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      state      <= HOLD;
      cnt        <= '0;
      rst_core_n <= 1'b0;
      rst_disp_n <= 1'b0;
      rst_scan_n <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rst_core_n <= (state_nxt >= REL_CORE) && (state_nxt <= DONE);
      rst_disp_n <= (state_nxt >= REL_DISP) && (state_nxt <= DONE);
      rst_scan_n <= (state_nxt >= REL_SCAN) && (state_nxt <= DONE);
      seq_done   <= (state_nxt == DONE);
    end
  end

  assign seq_state = state;

endmodule
